// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             i_valid_EX;
  logic             o_ready_EX;
  logic [2:0]       i_op_EX;
  logic [WIDTH-1:0] i_rs1_EX;
  logic [WIDTH-1:0] i_rs2_EX;
  logic             i_flush_EX;
  logic             o_valid_EX;
  logic             i_result_ready_EX;
  logic [WIDTH-1:0] o_result_EX;

  modport slave (
    input  i_valid_EX, i_op_EX, i_rs1_EX, i_rs2_EX, i_flush_EX, i_result_ready_EX,
    output o_ready_EX, o_valid_EX, o_result_EX
  );

  modport master (
    output i_valid_EX, i_op_EX, i_rs1_EX, i_rs2_EX, i_flush_EX, i_result_ready_EX,
    input  o_ready_EX, o_valid_EX, o_result_EX
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RISC-V style MUL/MULH*/DIV*/REM* unit: one shift-add or restoring-divide step per cycle.
// Optional macro MULDIV_EARLY_OUT_EN: trivial cases (zero operand, divide by zero, overflow) finish at accept.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     i_clk,
  input  logic     i_rst,
  muldiv_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  localparam int CW = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [2:0]         op_q, op_d;
  logic               sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;

  logic               a_signed, b_signed, sign_a, sign_b, div_op;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_sum, shifted, sub_diff;
  logic [2*WIDTH-1:0] mul_full;
  logic [WIDTH-1:0]   quo_fin, rem_fin;
  logic               early;
  logic [WIDTH-1:0]   early_res;

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    apply_sign = neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign_wide(input logic [2*WIDTH-1:0] v, input logic neg);
    apply_sign_wide = neg ? -v : v;
  endfunction

  always_comb begin
    div_op   = bus.i_op_EX[2];
    a_signed = bus.i_op_EX inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
    b_signed = bus.i_op_EX inside {3'd0, 3'd1, 3'd4, 3'd6};
    sign_a   = a_signed & bus.i_rs1_EX[WIDTH-1];
    sign_b   = b_signed & bus.i_rs2_EX[WIDTH-1];
    mag_a    = apply_sign(bus.i_rs1_EX, sign_a);
    mag_b    = apply_sign(bus.i_rs2_EX, sign_b);
`ifdef MULDIV_EARLY_OUT_EN
    early     = 1'b0;
    early_res = '0;
    if (!div_op) begin
      early = (bus.i_rs1_EX == '0) || (bus.i_rs2_EX == '0);
    end else if (bus.i_rs2_EX == '0) begin
      early     = 1'b1;
      early_res = bus.i_op_EX[1] ? bus.i_rs1_EX : '1;
    end else if (!bus.i_op_EX[0] && bus.i_rs1_EX == {1'b1, {(WIDTH-1){1'b0}}} && bus.i_rs2_EX == '1) begin
      early     = 1'b1;
      early_res = bus.i_op_EX[1] ? '0 : bus.i_rs1_EX;
    end
`else
    early     = 1'b0;
    early_res = '0;
`endif
  end

  // Datapath steps on the shared product / remainder:quotient register
  always_comb begin
    add_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    shifted  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    sub_diff = shifted - {1'b0, opb_q};
    mul_full = apply_sign_wide(prod_q, sa_q ^ sb_q);
    quo_fin  = dz_q ? '1 : apply_sign(prod_q[WIDTH-1:0], sa_q ^ sb_q);
    rem_fin  = apply_sign(prod_q[2*WIDTH-1:WIDTH], sa_q);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    opb_d    = opb_q;
    result_d = result_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    dz_d     = dz_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid_EX && !bus.i_flush_EX) begin
          op_d   = bus.i_op_EX;
          sa_d   = sign_a;
          sb_d   = sign_b;
          dz_d   = div_op && (bus.i_rs2_EX == '0);
          prod_d = {{WIDTH{1'b0}}, div_op ? mag_a : mag_b};
          opb_d  = div_op ? mag_b : mag_a;
          cnt_d  = CW'(WIDTH);
          if (early) begin
            result_d = early_res;
            state_d  = DONE;
          end else begin
            state_d = div_op ? DIV : MUL;
          end
        end
      end
      MUL: begin
        if (cnt_q == '0) begin
          result_d = (op_q == 3'd0) ? mul_full[WIDTH-1:0] : mul_full[2*WIDTH-1:WIDTH];
          state_d  = DONE;
        end else begin
          prod_d = prod_q[0] ? {add_sum, prod_q[WIDTH-1:1]} : {1'b0, prod_q[2*WIDTH-1:1]};
          cnt_d  = cnt_q - CW'(1);
        end
      end
      DIV: begin
        if (cnt_q == '0) begin
          result_d = op_q[1] ? rem_fin : quo_fin;
          state_d  = DONE;
        end else begin
          prod_d = !sub_diff[WIDTH] ? {sub_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1}
                                    : {shifted[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
          cnt_d  = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (bus.i_result_ready_EX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.i_flush_EX) state_d = IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      opb_q    <= '0;
      result_q <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.o_ready_EX  = (state_q == IDLE);
  assign bus.o_valid_EX  = (state_q == DONE);
  assign bus.o_result_EX = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random and directed requests against an arithmetic reference model.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  int   cycle = 0;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
    int          hold;
  } exp_t;
  exp_t sb[$];

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  muldiv_if #(.WIDTH(32)) bus ();
  muldiv_unit #(.WIDTH(32)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sbv = longint'($signed(b));
    longint      ua = longint'({32'b0, a});
    longint      ub = longint'({32'b0, b});
    logic [63:0] p;
    bit          ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sbv; return p[31:0]; end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit special;
    if (op < 3'd4) special = (a == 0) || (b == 0);
    else special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (EARLY && special) ? 1 : 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Request held until a ready cycle; afterwards operands are scrambled to show they are not re-sampled.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit track, input int hold);
    int waited = 0;
    @(negedge clk);
    bus.i_valid_EX = 1'b1;
    bus.i_op_EX    = op;
    bus.i_rs1_EX   = a;
    bus.i_rs2_EX   = b;
    while (!bus.o_ready_EX && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.o_ready_EX) begin
      check("ready_timeout", 0, 1);
      bus.i_valid_EX = 1'b0;
      return;
    end
    @(negedge clk);
    bus.i_valid_EX = 1'b0;
    bus.i_op_EX    = 3'($urandom);
    bus.i_rs1_EX   = $urandom;
    bus.i_rs2_EX   = $urandom;
    check("ready_low_after_accept", bus.o_ready_EX, 0);
    if (track) sb.push_back('{ref_model(op, a, b), cycle, exp_lat(op, a, b), hold});
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor / consumer: compares each presented result with the scoreboard head
  initial begin
    exp_t        e;
    bit          prev_v = 1'b0;
    bit          consumed = 1'b0;
    int          hc = 0;
    logic [31:0] held = '0;
    e = '{32'h0, 0, 0, 0};
    forever begin
      @(negedge clk);
      if (consumed) begin
        check("idle_after_consume_ready", bus.o_ready_EX, 1);
        check("idle_after_consume_valid", bus.o_valid_EX, 0);
        consumed = 1'b0;
      end
      if (rst) begin
        prev_v = 1'b0;
        bus.i_result_ready_EX = 1'b0;
      end else if (bus.o_valid_EX === 1'b1) begin
        if (!prev_v) begin
          hc = 0;
          held = bus.o_result_EX;
          if (sb.size() == 0) begin
            check("spurious_valid", bus.o_valid_EX, 0);
            e.hold = 0;
          end else begin
            e = sb[0];
            check("latency", 64'(cycle - e.acc), 64'(e.lat));
            check("result", bus.o_result_EX, e.res);
          end
        end else begin
          check("hold_result_stable", bus.o_result_EX, held);
          check("hold_ready_low", bus.o_ready_EX, 0);
        end
        if (hc >= e.hold) begin
          bus.i_result_ready_EX = 1'b1;
          if (sb.size() != 0) void'(sb.pop_front());
          consumed = 1'b1;
          prev_v = 1'b0;
        end else begin
          bus.i_result_ready_EX = 1'b0;
          hc++;
          prev_v = 1'b1;
        end
      end else begin
        bus.i_result_ready_EX = 1'b0;
        prev_v = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.i_valid_EX = 1'b0;
    bus.i_op_EX = 3'd0;
    bus.i_rs1_EX = '0;
    bus.i_rs2_EX = '0;
    bus.i_flush_EX = 1'b0;
    bus.i_result_ready_EX = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", bus.o_ready_EX, 1);
    check("reset_valid", bus.o_valid_EX, 0);
    check("reset_result", bus.o_result_EX, 0);
    rst = 1'b0;

    issue(3'd0, 32'd7, 32'd6, 1'b1, 0);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, 0);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1, 2);
    issue(3'd5, 32'd5, 32'd0, 1'b1, 0);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    issue(3'd4, 32'hFFFF_FFF9, 32'd0, 1'b1, 0);
    issue(3'd0, 32'd0, 32'd12345, 1'b1, 0);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5);
    for (int i = 0; i < 60; i++)
      issue(3'($urandom_range(0, 7)), pick(), pick(), 1'b1, $urandom_range(0, 3));
    drain();

    // Flush during a division: back to idle, result discarded
    issue(3'd4, 32'd1000, 32'd7, 1'b0, 0);
    repeat (9) @(negedge clk);
    bus.i_flush_EX = 1'b1;
    @(negedge clk);
    bus.i_flush_EX = 1'b0;
    check("flush_ready", bus.o_ready_EX, 1);
    check("flush_valid", bus.o_valid_EX, 0);
    repeat (40) @(negedge clk);
    check("flush_no_late_valid", bus.o_valid_EX, 0);

    // Flush beats a simultaneous request
    bus.i_valid_EX = 1'b1;
    bus.i_flush_EX = 1'b1;
    bus.i_op_EX    = 3'd0;
    bus.i_rs1_EX   = 32'd3;
    bus.i_rs2_EX   = 32'd4;
    @(negedge clk);
    bus.i_valid_EX = 1'b0;
    bus.i_flush_EX = 1'b0;
    check("flush_vs_valid_ready", bus.o_ready_EX, 1);
    repeat (40) @(negedge clk);
    check("flush_vs_valid_no_valid", bus.o_valid_EX, 0);

    // Reset in the middle of a multiply
    issue(3'd0, 32'd123, 32'd456, 1'b0, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_ready", bus.o_ready_EX, 1);
    check("midreset_result", bus.o_result_EX, 0);
    check("midreset_valid", bus.o_valid_EX, 0);
    rst = 1'b0;

    issue(3'd7, 32'd100, 32'd7, 1'b1, 0);
    issue(3'd1, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 1'b1, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
